symbol_upsampler: RTL and testbench

Transmit-side counterpart to the receive symbol-timing/decimation path. It takes one 32-bit complex symbol per AXI-Stream beat and emits N output samples per symbol. Each symbol is either held for N samples or followed by N-1 zeros, which feeds a downstream pulse-shaping filter. It sits inside an RFNoC block between the input and output `axi_fifo_flop` pipeline stages of the AXI wrapper, in the `ce_clk` domain.

---
 rtl/symbol_upsampler.sv | 99 +++++++++
 tb/tb_symbol_upsampler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_upsampler.sv
// Transmit symbol upsampler: expands each input symbol into N output samples,
// either repeating the symbol (sample-and-hold) or following it with N-1 zeros.
module symbol_upsampler #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_WIDTH-1:0] n,
  input  logic               zero_stuff,
  input  logic [WIDTH-1:0]   i_tdata,
  input  logic               i_tlast,
  input  logic               i_tvalid,
  output logic               i_tready,
  output logic [WIDTH-1:0]   o_tdata,
  output logic               o_tlast,
  output logic               o_tvalid,
  input  logic               o_tready,
  output logic               busy,
  output logic [31:0]        sym_count
);

  logic [WIDTH-1:0]   r_sym;
  logic               r_last;
  logic [N_WIDTH-1:0] r_n;
  logic               r_zs;
  logic [N_WIDTH-1:0] r_phase;
  logic [WIDTH-1:0]   r_data_p0;
  logic               r_last_p0;
  logic               r_vld_p0;
  logic [31:0]        r_sym_count;

  logic [N_WIDTH-1:0] w_n_eff;
  logic [N_WIDTH-1:0] w_n_m1;
  logic [N_WIDTH-1:0] w_phase_nxt;
  logic               w_last_phase;
  logic               w_accept;
  logic               w_beat;

  // A rate of zero behaves as a rate of one.
  function automatic logic [N_WIDTH-1:0] f_rate_eff(input logic [N_WIDTH-1:0] rate);
    return (rate == '0) ? N_WIDTH'(1) : rate;
  endfunction

  assign w_n_eff      = f_rate_eff(n);
  assign w_n_m1       = r_n - N_WIDTH'(1);
  assign w_phase_nxt  = r_phase + N_WIDTH'(1);
  assign w_last_phase = (r_phase == w_n_m1);

  assign i_tready = !rst && (!r_vld_p0 || (o_tready && w_last_phase));
  assign w_accept = i_tvalid && i_tready;
  assign w_beat   = r_vld_p0 && o_tready;

  // Symbol capture: the held symbol itself needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sym <= i_tdata;
    end
  end

  // Output stage p0: per-symbol settings latched on accept, phase walks to n-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0    <= 1'b0;
      r_data_p0   <= '0;
      r_last_p0   <= 1'b0;
      r_last      <= 1'b0;
      r_n         <= N_WIDTH'(1);
      r_zs        <= 1'b0;
      r_phase     <= '0;
      r_sym_count <= '0;
    end else if (w_accept) begin
      r_last      <= i_tlast;
      r_n         <= w_n_eff;
      r_zs        <= zero_stuff;
      r_phase     <= '0;
      r_data_p0   <= i_tdata;
      r_last_p0   <= i_tlast && (w_n_eff == N_WIDTH'(1));
      r_vld_p0    <= 1'b1;
      r_sym_count <= r_sym_count + 32'd1;
    end else if (w_beat) begin
      if (w_last_phase) begin
        r_vld_p0  <= 1'b0;
        r_last_p0 <= 1'b0;
      end else begin
        r_phase   <= w_phase_nxt;
        r_data_p0 <= r_zs ? '0 : r_sym;
        r_last_p0 <= r_last && (w_phase_nxt == w_n_m1);
      end
    end
  end

  assign o_tdata   = r_data_p0;
  assign o_tlast   = r_last_p0;
  assign o_tvalid  = r_vld_p0;
  assign busy      = r_vld_p0;
  assign sym_count = r_sym_count;

endmodule

// File: tb/tb_symbol_upsampler.sv
// Self-checking bench for symbol_upsampler: constant vector table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_symbol_upsampler;
  localparam int WIDTH   = 32;
  localparam int N_WIDTH = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_WIDTH-1:0] n;
  logic               zero_stuff;
  logic [WIDTH-1:0]   i_tdata;
  logic               i_tlast;
  logic               i_tvalid;
  logic               i_tready;
  logic [WIDTH-1:0]   o_tdata;
  logic               o_tlast;
  logic               o_tvalid;
  logic               o_tready;
  logic               busy;
  logic [31:0]        sym_count;

  symbol_upsampler #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .n         (n),
    .zero_stuff(zero_stuff),
    .i_tdata   (i_tdata),
    .i_tlast   (i_tlast),
    .i_tvalid  (i_tvalid),
    .i_tready  (i_tready),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
    .busy      (busy),
    .sym_count (sym_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      n;
    logic             zs;
    logic [31:0]      d;
    logic             l;
    int               len;
    logic [3:0][31:0] e;
    logic [3:0]       elast;
  } vec_t;

  vec_t tbl[7];

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [32:0] exp_q[$];
  logic [32:0] cap_q[$];
  int          cap_cyc[$];
  int          acc_cyc[$];
  logic [31:0] exp_cnt = 32'd0;
  logic        held_v = 1'b0;
  logic [32:0] held = '0;
  logic        last_acc = 1'b0;
  logic [31:0] din[16];

  function automatic vec_t mk(input logic [15:0] nv, input logic zs, input logic [31:0] d,
                              input logic l, input int len, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic [3:0] el);
    vec_t v;
    v.n = nv; v.zs = zs; v.d = d; v.l = l; v.len = len;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    v.elast = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: inputs are already driven at the falling edge; check, then
  // update the model with whatever handshakes the coming rising edge completes.
  task automatic step();
    logic        acc;
    logic        beat;
    logic [32:0] e;
    int          nn;
    #1;
    chk("o_tvalid", 64'(o_tvalid), 64'(exp_q.size() != 0));
    chk("busy", 64'(busy), 64'(exp_q.size() != 0));
    chk("sym_count", 64'(sym_count), 64'(exp_cnt));
    if (rst) chk("i_tready_rst", 64'(i_tready), 64'd0);
    else chk("i_tready", 64'(i_tready),
             64'((exp_q.size() == 0) || (o_tready && exp_q.size() == 1)));
    if (held_v) chk("stall_hold", 64'({o_tlast, o_tdata}), 64'(held));
    acc  = i_tvalid && i_tready && !rst;
    beat = o_tvalid && o_tready && !rst;
    if (rst) begin
      exp_q.delete();
      exp_cnt = 32'd0;
    end else begin
      if (beat) begin
        if (exp_q.size() == 0) chk("extra_beat", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          chk("beat", 64'({o_tlast, o_tdata}), 64'(e));
        end
        cap_q.push_back({o_tlast, o_tdata});
        cap_cyc.push_back(cyc);
      end
      if (acc) begin
        nn = (n == 0) ? 1 : int'(n);
        for (int k = 0; k < nn; k++)
          exp_q.push_back({(i_tlast && k == nn - 1), ((k == 0) || !zero_stuff) ? i_tdata : 32'h0});
        exp_cnt++;
        acc_cyc.push_back(cyc);
      end
    end
    last_acc = acc;
    held_v   = o_tvalid && !o_tready && !rst;
    held     = {o_tlast, o_tdata};
    @(negedge clk);
    cyc++;
  endtask

  task automatic push_until_acc(input logic [31:0] d, input logic l, input logic [15:0] nv,
                                input logic zs, input int budget);
    int c = 0;
    i_tvalid = 1'b1; i_tdata = d; i_tlast = l; n = nv; zero_stuff = zs; o_tready = 1'b1;
    last_acc = 1'b0;
    while (!last_acc && c < budget) begin
      step();
      c++;
    end
    chk("accept", 64'(last_acc), 64'd1);
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [15:0] nv,
                      input logic zs, input int budget);
    push_until_acc(d, l, nv, zs, budget);
    i_tvalid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    while ((o_tvalid || exp_q.size() != 0) && c < budget) begin
      step();
      c++;
    end
    chk("drained", 64'(o_tvalid), 64'd0);
  endtask

  task automatic clear_cap();
    cap_q.delete();
    cap_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic rand_run(input int nsym, input logic fixed2, input int budget);
    int   sent = 0;
    int   c = 0;
    logic pend = 1'b0;
    while (sent < nsym && c < budget) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend       = 1'b1;
        i_tvalid   = 1'b1;
        i_tdata    = $urandom;
        i_tlast    = 1'($urandom_range(0, 1));
        n          = fixed2 ? 16'd2 : 16'($urandom_range(0, 5));
        zero_stuff = 1'($urandom_range(0, 1));
      end
      o_tready = 1'($urandom_range(0, 1));
      step();
      c++;
      if (last_acc) begin
        sent++;
        pend     = 1'b0;
        i_tvalid = 1'b0;
      end
    end
    drain(budget);
    chk("rand_sent", 64'(sent), 64'(nsym));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; n = 16'd4; zero_stuff = 1'b0; i_tdata = '0; i_tlast = 1'b0;
    i_tvalid = 1'b0; o_tready = 1'b1;

    tbl[0] = mk(16'd4, 1'b0, 32'h00010002, 1'b0, 4, 32'h00010002, 32'h00010002, 32'h00010002, 32'h00010002, 4'b0000);
    tbl[1] = mk(16'd4, 1'b0, 32'h00030004, 1'b1, 4, 32'h00030004, 32'h00030004, 32'h00030004, 32'h00030004, 4'b1000);
    tbl[2] = mk(16'd3, 1'b1, 32'h7FFF8001, 1'b1, 3, 32'h7FFF8001, 32'h0, 32'h0, 32'h0, 4'b0100);
    tbl[3] = mk(16'd0, 1'b0, 32'hDEADBEEF, 1'b1, 1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 4'b0001);
    tbl[4] = mk(16'd1, 1'b1, 32'h12345678, 1'b0, 1, 32'h12345678, 32'h0, 32'h0, 32'h0, 4'b0000);
    tbl[5] = mk(16'd2, 1'b1, 32'hAAAA5555, 1'b1, 2, 32'hAAAA5555, 32'h0, 32'h0, 32'h0, 4'b0010);
    tbl[6] = mk(16'd2, 1'b0, 32'h80000001, 1'b0, 2, 32'h80000001, 32'h80000001, 32'h0, 32'h0, 4'b0000);

    @(posedge clk);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk("rst_tdata", 64'(o_tdata), 64'd0);
    chk("rst_tlast", 64'(o_tlast), 64'd0);

    // Hold mode, N=4, two back-to-back symbols
    clear_cap();
    push_until_acc(32'h00010002, 1'b0, 16'd4, 1'b0, 10);
    push_until_acc(32'h00030004, 1'b1, 16'd4, 1'b0, 10);
    drain(20);
    chk("hold_len", 64'(cap_q.size()), 64'd8);
    chk("hold_count", 64'(sym_count), 64'd2);
    if (cap_q.size() == 8 && acc_cyc.size() == 2) begin
      chk("hold_acc_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd4);
      chk("hold_b3", 64'(cap_q[3]), 64'({1'b0, 32'h00010002}));
      chk("hold_b4", 64'(cap_q[4]), 64'({1'b0, 32'h00030004}));
      chk("hold_b6", 64'(cap_q[6]), 64'({1'b0, 32'h00030004}));
      chk("hold_b7", 64'(cap_q[7]), 64'({1'b1, 32'h00030004}));
      chk("hold_span", 64'(cap_cyc[7] - cap_cyc[0]), 64'd7);
    end

    // Vector table, one isolated symbol each
    for (int t = 0; t < 7; t++) begin
      clear_cap();
      send(tbl[t].d, tbl[t].l, tbl[t].n, tbl[t].zs, 20);
      drain(40);
      chk($sformatf("tbl%0d_len", t), 64'(cap_q.size()), 64'(tbl[t].len));
      for (int k = 0; k < tbl[t].len && k < cap_q.size(); k++)
        chk($sformatf("tbl%0d_beat%0d", t, k), 64'(cap_q[k]), 64'({tbl[t].elast[k], tbl[t].e[k]}));
    end

    // N=0 and N=1 streaming, 16 symbols with valid held high
    for (int m = 0; m < 2; m++) begin
      clear_cap();
      for (int i = 0; i < 16; i++) begin
        din[i] = $urandom;
        push_until_acc(din[i], 1'(i == 15), 16'(m), 1'(i % 2), 4);
      end
      i_tvalid = 1'b0;
      drain(10);
      chk($sformatf("n%0d_len", m), 64'(cap_q.size()), 64'd16);
      if (cap_q.size() == 16 && acc_cyc.size() == 16) begin
        chk($sformatf("n%0d_latency", m), 64'(cap_cyc[0] - acc_cyc[0]), 64'd1);
        chk($sformatf("n%0d_out_span", m), 64'(cap_cyc[15] - cap_cyc[0]), 64'd15);
        chk($sformatf("n%0d_in_span", m), 64'(acc_cyc[15] - acc_cyc[0]), 64'd15);
        for (int i = 0; i < 16; i++)
          chk($sformatf("n%0d_beat%0d", m, i), 64'(cap_q[i]), 64'({1'(i == 15), din[i]}));
      end
    end

    // Rate change after the second output beat of an N=4 symbol
    clear_cap();
    push_until_acc(32'hA5A50001, 1'b0, 16'd4, 1'b0, 10);
    i_tdata = 32'h5A5A0002;
    i_tlast = 1'b1;
    step();
    step();
    n = 16'd2;
    push_until_acc(32'h5A5A0002, 1'b1, 16'd2, 1'b0, 10);
    i_tvalid = 1'b0;
    drain(20);
    chk("rate_len", 64'(cap_q.size()), 64'd6);
    if (cap_q.size() == 6) begin
      chk("rate_b3", 64'(cap_q[3]), 64'({1'b0, 32'hA5A50001}));
      chk("rate_b4", 64'(cap_q[4]), 64'({1'b0, 32'h5A5A0002}));
      chk("rate_b5", 64'(cap_q[5]), 64'({1'b1, 32'h5A5A0002}));
    end

    // Reset while at phase 1 of an N=4 symbol
    clear_cap();
    send(32'h11112222, 1'b1, 16'd4, 1'b0, 10);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_vld", 64'(o_tvalid), 64'd0);
    chk("midrst_last", 64'(o_tlast), 64'd0);
    chk("midrst_cnt", 64'(sym_count), 64'd0);
    clear_cap();
    send(32'h33334444, 1'b1, 16'd2, 1'b1, 10);
    drain(20);
    chk("postrst_len", 64'(cap_q.size()), 64'd2);
    if (cap_q.size() == 2) begin
      chk("postrst_b0", 64'(cap_q[0]), 64'({1'b0, 32'h33334444}));
      chk("postrst_b1", 64'(cap_q[1]), 64'({1'b1, 32'h0}));
    end

    // Randomized backpressure: fixed N=2, then random N and mode
    rand_run(100, 1'b1, 3000);
    rand_run(150, 1'b0, 6000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
